mod_m_counter_prog: RTL and testbench

Runtime-programmable mod-M counter, the successor to the fixed mod-M counter. It counts up or down, runs free-running (continuous) or one-shot, and accepts synchronous load and clear. Modulus changes are shadowed and take effect at the next wrap. Used as a programmable tick and timebase generator.

---
 rtl/mod_counter_pkg.sv | 19 +
 rtl/mod_m_counter_prog.sv | 125 ++++++++++++
 tb/tb_mod_m_counter_prog.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mod_counter_pkg.sv
// Shared types and constants for the programmable mod-M counter.
package mod_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    localparam int unsigned MOD_MIN = 2;

    // A modulus below 2 has no meaningful count range, so it is raised to 2.
    function automatic int unsigned clamp_mod(input int unsigned m);
        return (m < MOD_MIN) ? MOD_MIN : m;
    endfunction

endpackage

// File: rtl/mod_m_counter_prog.sv
// Runtime-programmable up/down mod-M counter with continuous and one-shot modes.
// A modulus write is held in a shadow register and takes effect at the next wrap.
module mod_m_counter_prog
    import mod_counter_pkg::*;
#(
    parameter int N         = 4,
    parameter int M_DEFAULT = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up_down,
    input  logic         one_shot,
    input  logic         start,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_value,
    input  logic         mod_wr,
    input  logic [N-1:0] mod_value,
    output logic [N-1:0] count,
    output logic         complete_tick,
    output logic         done,
    output logic [N-1:0] mod_active
);

    localparam logic [N-1:0] ONE    = N'(1);
    localparam logic [N-1:0] M_RST  = N'(M_DEFAULT);

    state_t       state, state_nxt;
    logic [N-1:0] count_nxt;
    logic [N-1:0] mod_nxt;
    logic [N-1:0] shadow, shadow_nxt;
    logic         pending, pending_nxt;
    logic         os_mode, os_mode_nxt;

    logic [N-1:0] mod_in;
    logic [N-1:0] term;
    logic [N-1:0] m_wrap;
    logic [N-1:0] m_start;
    logic         at_term;
    logic         stale;
    logic         stepping;
    logic         wrap_edge;

    always_comb begin
        mod_in    = N'(clamp_mod(32'(mod_value)));
        term      = (up_down == DIR_UP) ? (mod_active - ONE) : '0;
        at_term   = (count == term);
        // A count left above the range by a modulus shrink is pulled back at the next step.
        stale     = (count > (mod_active - ONE));
        // An incoming write on the wrap edge wins over an older shadow value.
        m_wrap    = mod_wr ? mod_in : (pending ? shadow : mod_active);
        m_start   = (state != RUN && pending) ? shadow : mod_active;
        stepping  = (state == RUN) && en;
        wrap_edge = stepping && (at_term || stale) && !clear && !load && !start;

        complete_tick = stepping && at_term;
        done          = (state == DONE);
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        os_mode_nxt = os_mode;

        if (clear) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else if (load) begin
            count_nxt = (load_value < mod_active) ? load_value : (mod_active - ONE);
        end else if (start) begin
            state_nxt   = RUN;
            count_nxt   = (up_down == DIR_UP) ? '0 : (m_start - ONE);
            os_mode_nxt = one_shot;
        end else if (stepping) begin
            if (at_term && os_mode) begin
                state_nxt = DONE;
            end else if (at_term || stale) begin
                count_nxt = (up_down == DIR_UP) ? '0 : (m_wrap - ONE);
            end else begin
                count_nxt = (up_down == DIR_UP) ? (count + ONE) : (count - ONE);
            end
        end
    end

    always_comb begin
        mod_nxt     = mod_active;
        shadow_nxt  = shadow;
        pending_nxt = pending;

        if (wrap_edge && (mod_wr || pending)) begin
            mod_nxt     = m_wrap;
            shadow_nxt  = m_wrap;
            pending_nxt = 1'b0;
        end else begin
            if (state != RUN && pending) begin
                mod_nxt     = shadow;
                pending_nxt = 1'b0;
            end
            if (mod_wr) begin
                shadow_nxt  = mod_in;
                pending_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            mod_active <= M_RST;
            shadow     <= M_RST;
            pending    <= 1'b0;
            os_mode    <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            mod_active <= mod_nxt;
            shadow     <= shadow_nxt;
            pending    <= pending_nxt;
            os_mode    <= os_mode_nxt;
        end
    end

endmodule

// File: tb/tb_mod_m_counter_prog.sv
// Vector-table bench for mod_m_counter_prog: each vector is driven, its expectation queued,
// and compared one clock later.
module tb_mod_m_counter_prog;

    localparam int N  = 4;
    localparam int MD = 12;

    logic         clk = 1'b0;
    logic         reset, en, up_down, one_shot, start, clear, load, mod_wr;
    logic [N-1:0] load_value, mod_value;
    logic [N-1:0] count, mod_active;
    logic         complete_tick, done;

    always #5 clk = ~clk;

    mod_m_counter_prog #(.N(N), .M_DEFAULT(MD)) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .up_down       (up_down),
        .one_shot      (one_shot),
        .start         (start),
        .clear         (clear),
        .load          (load),
        .load_value    (load_value),
        .mod_wr        (mod_wr),
        .mod_value     (mod_value),
        .count         (count),
        .complete_tick (complete_tick),
        .done          (done),
        .mod_active    (mod_active)
    );

    typedef struct {
        logic         rst, en, ud, os, st, clr, ld, mw;
        logic [N-1:0] lv, mv;
        logic [N-1:0] cnt;
        logic         tick, dn;
        logic [N-1:0] mod;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    function automatic void add(input logic rst, input logic en_i, input logic ud, input logic os,
                                input logic st, input logic clr, input logic ld, input int lv,
                                input logic mw, input int mv, input int cnt, input logic tick,
                                input logic dn, input int mod);
        vec_t v;
        v.rst = rst; v.en = en_i; v.ud = ud; v.os = os; v.st = st; v.clr = clr; v.ld = ld;
        v.lv = N'(lv); v.mw = mw; v.mv = N'(mv);
        v.cnt = N'(cnt); v.tick = tick; v.dn = dn; v.mod = N'(mod);
        vecs.push_back(v);
    endfunction

    // Plain enabled step, no control strobes.
    function automatic void stp(input logic ud, input int cnt, input logic tick, input int mod);
        add(1, 1, ud, 0, 0, 0, 0, 0, 0, 0, cnt, tick, 0, mod);
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL v%0d %s: got %0d expected %0d", idx, name, act, expv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e;
        reset = 0; en = 0; up_down = 0; one_shot = 0; start = 0; clear = 0; load = 0;
        mod_wr = 0; load_value = '0; mod_value = '0;

        // Reset state
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);
        // Continuous up, two full periods of 12
        add(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 12);
        for (int i = 1; i <= 24; i++) stp(1, i % 12, (i % 12) == 11, 12);
        // Continuous down with a 3-cycle enable gap
        add(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 11, 0, 0, 12);
        for (int i = 1; i <= 5; i++) stp(0, 11 - i, 0, 12);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 12);
        for (int i = 6; i <= 13; i++) stp(0, 11 - (i % 12), (11 - (i % 12)) == 0, 12);
        // Direction changes mid-count: 10 -> up 11 (terminal) -> wrap 0 -> down wraps to 11
        stp(1, 11, 1, 12);
        stp(1, 0, 0, 12);
        stp(0, 11, 0, 12);
        stp(0, 10, 0, 12);
        // Shadowed modulus: written at count 5, applied at the wrap after 11
        add(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 12);
        for (int i = 1; i <= 5; i++) stp(1, i, 0, 12);
        add(1, 1, 1, 0, 0, 0, 0, 0, 1, 6, 6, 0, 0, 12);
        for (int i = 7; i <= 11; i++) stp(1, i, i == 11, 12);
        stp(1, 0, 0, 6);
        for (int i = 1; i <= 5; i++) stp(1, i, i == 5, 6);
        // Write on the wrap edge itself, value 1 clamps to 2
        add(1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2);
        stp(1, 1, 1, 2);
        stp(1, 0, 0, 2);
        // Clear, then modulus 4 written in IDLE applies on the following edge
        add(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2);
        add(1, 1, 1, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 2);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        // One-shot M=4
        add(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        stp(1, 1, 0, 4);
        stp(1, 2, 0, 4);
        stp(1, 3, 1, 4);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 4);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 4);
        add(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        stp(1, 1, 0, 4);
        // Load clamping with M=6
        add(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4);
        add(1, 1, 1, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 4);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
        add(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6);
        add(1, 1, 1, 0, 0, 0, 1, 9, 0, 0, 5, 1, 0, 6);
        add(1, 1, 1, 0, 0, 0, 1, 3, 0, 0, 3, 0, 0, 6);
        stp(1, 4, 0, 6);
        stp(1, 5, 1, 6);
        stp(1, 0, 0, 6);
        // Back to M=12, then clear at count 7
        add(1, 1, 1, 0, 0, 0, 0, 0, 1, 12, 1, 0, 0, 6);
        for (int i = 2; i <= 5; i++) stp(1, i, i == 5, 6);
        stp(1, 0, 0, 12);
        for (int i = 1; i <= 7; i++) stp(1, i, 0, 12);
        add(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 12);
        // Reset mid-run discards a pending modulus
        add(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 12);
        stp(1, 1, 0, 12);
        stp(1, 2, 0, 12);
        add(1, 1, 1, 0, 0, 0, 0, 0, 1, 5, 3, 0, 0, 12);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; en = vecs[i].en; up_down = vecs[i].ud; one_shot = vecs[i].os;
            start = vecs[i].st; clear = vecs[i].clr; load = vecs[i].ld; load_value = vecs[i].lv;
            mod_wr = vecs[i].mw; mod_value = vecs[i].mv;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk("count", i, int'(count), int'(e.cnt));
            chk("complete_tick", i, int'(complete_tick), int'(e.tick));
            chk("done", i, int'(done), int'(e.dn));
            chk("mod_active", i, int'(mod_active), int'(e.mod));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
